// File: rtl/bus_sequencer.sv
// Shared-bus time-division sequencer: a 16-cycle frame with an SPI slot (counts 0-6),
// a turnaround cycle (count 7) and a CPU slot (counts 8-15). Every output is a flop;
// next-state values are decoded from the counter's next value so that each output
// lines up with the count it belongs to.
module bus_sequencer #(
  parameter int unsigned PHI2_START = 12
) (
  input  logic clk16_i,
  input  logic reset_ni,
  input  logic cpu_en_i,
  input  logic spi_valid_i,
  input  logic spi_rw_ni,
  output logic spi_ready_o,
  output logic spi_rd_strobe_o,
  input  logic bus_rw_ni,
  output logic cpu_clk_o,
  output logic cpu_be_o,
  output logic cpu_ready_o,
  output logic bus_addr_oe,
  output logic bus_rw_noe,
  output logic bus_data_oe,
  output logic ram_oe_o,
  output logic ram_we_o
);

  localparam logic [3:0] Phi2Start = 4'(PHI2_START);
  localparam logic [3:0] Phi2Next  = 4'(PHI2_START + 1);

  logic [3:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       grant_rw_q, grant_rw_d;

  logic spi_ready_q, spi_ready_d;
  logic spi_rd_strobe_q, spi_rd_strobe_d;
  logic cpu_clk_q, cpu_clk_d;
  logic cpu_be_q, cpu_be_d;
  logic cpu_ready_q, cpu_ready_d;
  logic bus_addr_oe_q, bus_addr_oe_d;
  logic bus_rw_noe_q, bus_rw_noe_d;
  logic bus_data_oe_q, bus_data_oe_d;
  logic ram_oe_q, ram_oe_d;
  logic ram_we_q, ram_we_d;

  // Frame counter and SPI grant state.
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q      <= 4'd0;
      grant_q    <= 1'b0;
      grant_rw_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_rw_q <= grant_rw_d;
    end
  end

  // Free-running count; grant sampled at the last count of a frame, retired after ready.
  always_comb begin
    cnt_d      = cnt_q + 4'd1;
    grant_d    = grant_q;
    grant_rw_d = grant_rw_q;
    if (cnt_q == 4'd15) begin
      grant_d    = spi_valid_i;
      grant_rw_d = spi_rw_ni;
    end else if (cnt_q == 4'd7) begin
      grant_d = 1'b0;
    end
  end

  // Decode outputs for the upcoming count (cnt_d) so the registered values match it.
  always_comb begin
    spi_ready_d     = 1'b0;
    spi_rd_strobe_d = 1'b0;
    bus_addr_oe_d   = 1'b0;
    bus_rw_noe_d    = 1'b0;
    bus_data_oe_d   = 1'b0;
    ram_oe_d        = 1'b0;
    ram_we_d        = 1'b0;
    cpu_be_d        = cnt_d[3];
    cpu_clk_d       = (cnt_d >= Phi2Start);
    // RDY only moves on entry to count 8, while PHI0 is low.
    cpu_ready_d     = (cnt_d == 4'd8) ? cpu_en_i : cpu_ready_q;
    if (cnt_d[3]) begin
      ram_oe_d = (cnt_d >= Phi2Start) & bus_rw_ni;
      ram_we_d = (cnt_d >= Phi2Next) & ~bus_rw_ni;
    end else if (grant_d) begin
      if (cnt_d <= 4'd6) begin
        bus_addr_oe_d = 1'b1;
        bus_rw_noe_d  = 1'b1;
      end
      if (!grant_rw_d) begin
        bus_data_oe_d = (cnt_d >= 4'd1) && (cnt_d <= 4'd6);
        ram_we_d      = (cnt_d >= 4'd3) && (cnt_d <= 4'd5);
      end else begin
        ram_oe_d        = (cnt_d >= 4'd2) && (cnt_d <= 4'd6);
        spi_rd_strobe_d = (cnt_d == 4'd6);
      end
      spi_ready_d = (cnt_d == 4'd7);
    end
  end

  // Output registers; reset forces every output low at once.
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      spi_ready_q     <= 1'b0;
      spi_rd_strobe_q <= 1'b0;
      cpu_clk_q       <= 1'b0;
      cpu_be_q        <= 1'b0;
      cpu_ready_q     <= 1'b0;
      bus_addr_oe_q   <= 1'b0;
      bus_rw_noe_q    <= 1'b0;
      bus_data_oe_q   <= 1'b0;
      ram_oe_q        <= 1'b0;
      ram_we_q        <= 1'b0;
    end else begin
      spi_ready_q     <= spi_ready_d;
      spi_rd_strobe_q <= spi_rd_strobe_d;
      cpu_clk_q       <= cpu_clk_d;
      cpu_be_q        <= cpu_be_d;
      cpu_ready_q     <= cpu_ready_d;
      bus_addr_oe_q   <= bus_addr_oe_d;
      bus_rw_noe_q    <= bus_rw_noe_d;
      bus_data_oe_q   <= bus_data_oe_d;
      ram_oe_q        <= ram_oe_d;
      ram_we_q        <= ram_we_d;
    end
  end

  assign spi_ready_o     = spi_ready_q;
  assign spi_rd_strobe_o = spi_rd_strobe_q;
  assign cpu_clk_o       = cpu_clk_q;
  assign cpu_be_o        = cpu_be_q;
  assign cpu_ready_o     = cpu_ready_q;
  assign bus_addr_oe     = bus_addr_oe_q;
  assign bus_rw_noe      = bus_rw_noe_q;
  assign bus_data_oe     = bus_data_oe_q;
  assign ram_oe_o        = ram_oe_q;
  assign ram_we_o        = ram_we_q;

endmodule
